// File: rtl/seg7_display_scanner.sv
// Time-multiplexed driver for a 4-digit common-anode seven-segment display.
// The digit bus is captured once per scan frame so that one frame never mixes old and new values.
module seg7_display_scanner #(
    parameter int unsigned REFRESH_DIV   = 100000,
    parameter bit          BLANK_LEADING = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] digit1,
    input  logic [3:0] digit2,
    input  logic [3:0] digit3,
    input  logic [3:0] digit4,
    input  logic       dot,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_tick
);

    localparam int unsigned     CntW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(REFRESH_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      slot_q, slot_d;
    logic [3:0]      sh1_q, sh2_q, sh3_q, sh4_q;
    logic            sh_dot_q;
    logic [3:0]      an_q, an_d;
    logic [6:0]      seg_q, seg_d;
    logic            dp_q, dp_d;
    logic            tick_q;

    logic            snap;
    logic [3:0]      e1, e2, e3, e4, code;
    logic            edot, blank;
    logic            z1, z12, z123;

    function automatic logic [6:0] decode(input logic [3:0] c);
        logic [6:0] s;
        case (c)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0111111;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    assign snap = (cnt_q == '0) && (slot_q == 2'd0);

    always_comb begin
        cnt_d  = cnt_q + 1'b1;
        slot_d = slot_q;
        if (cnt_q == CntMax) begin
            cnt_d  = '0;
            slot_d = slot_q + 2'd1;
        end

        // On the snapshot edge the shadows are still stale, so decode straight from the bus.
        e1   = snap ? digit1 : sh1_q;
        e2   = snap ? digit2 : sh2_q;
        e3   = snap ? digit3 : sh3_q;
        e4   = snap ? digit4 : sh4_q;
        edot = snap ? dot    : sh_dot_q;

        z1   = (e1 == 4'h0);
        z12  = z1 && (e2 == 4'h0) && !edot;
        z123 = z12 && (e3 == 4'h0);

        code  = e1;
        blank = 1'b0;
        an_d  = 4'b1111;
        unique case (slot_q)
            2'd0: begin code = e1; blank = z1;   an_d = 4'b0111; end
            2'd1: begin code = e2; blank = z12;  an_d = 4'b1011; end
            2'd2: begin code = e3; blank = z123; an_d = 4'b1101; end
            2'd3: begin code = e4; blank = 1'b0; an_d = 4'b1110; end
        endcase

        seg_d = (BLANK_LEADING && blank) ? 7'h7F : decode(code);
        dp_d  = !((slot_q == 2'd1) && edot);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            slot_q   <= 2'd0;
            sh1_q    <= 4'hF;
            sh2_q    <= 4'hF;
            sh3_q    <= 4'hF;
            sh4_q    <= 4'hF;
            sh_dot_q <= 1'b0;
            an_q     <= 4'b1111;
            seg_q    <= 7'h7F;
            dp_q     <= 1'b1;
            tick_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            slot_q <= slot_d;
            if (snap) begin
                sh1_q    <= digit1;
                sh2_q    <= digit2;
                sh3_q    <= digit3;
                sh4_q    <= digit4;
                sh_dot_q <= dot;
            end
            an_q   <= an_d;
            seg_q  <= seg_d;
            dp_q   <= dp_d;
            tick_q <= snap;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_display_scanner.sv
// Directed bench for seg7_display_scanner: a slow-scan blanking instance and a fast unblanked one.
module tb_seg7_display_scanner;

    typedef struct packed {
        logic [3:0] d1, d2, d3, d4;
        logic       dot;
        logic [6:0] s0, s1, s2, s3;
        logic       dp1;
    } vec_t;

    localparam int NVec = 9;

    logic       clk = 1'b0;
    logic       rst_a, rst_b;
    logic [3:0] a_d1, a_d2, a_d3, a_d4;
    logic       a_dot;
    logic [3:0] a_an, b_an;
    logic [6:0] a_seg, b_seg;
    logic       a_dp, b_dp, a_ft, b_ft;

    int checks = 0;
    int errors = 0;
    vec_t vecs[NVec];

    always #5 clk = ~clk;

    seg7_display_scanner #(.REFRESH_DIV(4), .BLANK_LEADING(1'b1)) u_dut_a (
        .clk(clk), .reset(rst_a),
        .digit1(a_d1), .digit2(a_d2), .digit3(a_d3), .digit4(a_d4), .dot(a_dot),
        .an(a_an), .seg(a_seg), .dp(a_dp), .frame_tick(a_ft)
    );

    seg7_display_scanner #(.REFRESH_DIV(1), .BLANK_LEADING(1'b0)) u_dut_b (
        .clk(clk), .reset(rst_b),
        .digit1(4'h0), .digit2(4'h0), .digit3(4'h0), .digit4(4'h7), .dot(1'b0),
        .an(b_an), .seg(b_seg), .dp(b_dp), .frame_tick(b_ft)
    );

    // Compares {an, seg, dp, frame_tick}.
    task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got an=%b seg=%b dp=%b ft=%b, expected an=%b seg=%b dp=%b ft=%b",
                     name, act[12:9], act[8:2], act[1], act[0],
                     exp[12:9], exp[8:2], exp[1], exp[0]);
        end
    endtask

    task automatic set_bus(input vec_t v);
        a_d1 = v.d1; a_d2 = v.d2; a_d3 = v.d3; a_d4 = v.d4; a_dot = v.dot;
    endtask

    // Starts at the negedge just before a snapshot edge; the bus is swapped to nxt mid slot1.
    task automatic run_frame(input vec_t v, input vec_t nxt, input string tag);
        logic [3:0] an_e;
        logic [6:0] seg_e;
        logic       dp_e;
        int         slot;
        set_bus(v);
        for (int j = 1; j <= 16; j++) begin
            @(posedge clk);
            @(negedge clk);
            slot = (j - 1) / 4;
            dp_e = 1'b1;
            case (slot)
                0:       begin an_e = 4'b0111; seg_e = v.s0; end
                1:       begin an_e = 4'b1011; seg_e = v.s1; dp_e = v.dp1; end
                2:       begin an_e = 4'b1101; seg_e = v.s2; end
                default: begin an_e = 4'b1110; seg_e = v.s3; end
            endcase
            check($sformatf("%s cyc%0d", tag, j), {a_an, a_seg, a_dp, a_ft},
                  {an_e, seg_e, dp_e, (j == 1)});
            if (j == 6) set_bus(nxt);
        end
    endtask

    initial begin
        //           d1    d2    d3    d4   dot  s0          s1          s2          s3          dp1
        vecs[0] = '{4'h9, 4'h9, 4'h9, 4'h9, 1'b1, 7'b0010000, 7'b0010000, 7'b0010000, 7'b0010000, 1'b0};
        vecs[1] = '{4'h1, 4'h2, 4'h3, 4'h4, 1'b0, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 1'b1};
        vecs[2] = '{4'h0, 4'h0, 4'h0, 4'h1, 1'b0, 7'b1111111, 7'b1111111, 7'b1111111, 7'b1111001, 1'b1};
        vecs[3] = '{4'h0, 4'h0, 4'h0, 4'h5, 1'b1, 7'b1111111, 7'b1000000, 7'b1000000, 7'b0010010, 1'b0};
        vecs[4] = '{4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000, 1'b1};
        vecs[5] = '{4'hA, 4'h6, 4'h6, 4'hF, 1'b0, 7'b0111111, 7'b0000010, 7'b0000010, 7'b1111111, 1'b1};
        vecs[6] = '{4'hB, 4'hC, 4'hD, 4'hE, 1'b0, 7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111, 1'b1};
        vecs[7] = '{4'h0, 4'h3, 4'h0, 4'h0, 1'b0, 7'b1111111, 7'b0110000, 7'b1000000, 7'b1000000, 1'b1};
        vecs[8] = '{4'h0, 4'h0, 4'h2, 4'h0, 1'b1, 7'b1111111, 7'b1000000, 7'b0100100, 7'b1000000, 1'b0};

        rst_a = 1'b1;
        rst_b = 1'b1;
        set_bus(vecs[0]);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("reset a cyc%0d", i), {a_an, a_seg, a_dp, a_ft},
                  {4'b1111, 7'h7F, 1'b1, 1'b0});
        end
        check("reset b", {b_an, b_seg, b_dp, b_ft}, {4'b1111, 7'h7F, 1'b1, 1'b0});
        rst_a = 1'b0;

        // Each frame also swaps the bus mid-frame, so later slots catch any tearing.
        for (int i = 0; i < NVec; i++)
            run_frame(vecs[i], vecs[(i + 1) % NVec], $sformatf("vec%0d", i));

        // Mid-frame reset during slot2.
        set_bus(vecs[1]);
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("pre-reset slot2", {a_an, a_seg, a_dp, a_ft}, {4'b1101, 7'b0110000, 1'b1, 1'b0});
        rst_a = 1'b1;
        #1;
        check("async reset", {a_an, a_seg, a_dp, a_ft}, {4'b1111, 7'h7F, 1'b1, 1'b0});
        @(negedge clk);
        check("reset held", {a_an, a_seg, a_dp, a_ft}, {4'b1111, 7'h7F, 1'b1, 1'b0});
        rst_a = 1'b0;
        run_frame(vecs[3], vecs[3], "post-reset");

        // Fast scan, no blanking: a new slot every cycle.
        rst_b = 1'b0;
        for (int j = 1; j <= 8; j++) begin
            logic [3:0] an_e;
            logic [6:0] seg_e;
            @(posedge clk);
            @(negedge clk);
            case ((j - 1) % 4)
                0:       begin an_e = 4'b0111; seg_e = 7'b1000000; end
                1:       begin an_e = 4'b1011; seg_e = 7'b1000000; end
                2:       begin an_e = 4'b1101; seg_e = 7'b1000000; end
                default: begin an_e = 4'b1110; seg_e = 7'b1111000; end
            endcase
            check($sformatf("fast cyc%0d", j), {b_an, b_seg, b_dp, b_ft},
                  {an_e, seg_e, 1'b1, ((j - 1) % 4 == 0)});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
